// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage: ALU ops in 1 cycle, shifts n cycles, MUL 8 cycles, then a write-back pulse.
// Optional multiplier built only when EXEC_MUL_EN is defined; otherwise OP=111 reports ILLEGAL.
module exec_unit_mc #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] OPA,
  input  logic [WIDTH-1:0] OPB,
  input  logic [WIDTH-1:0] OPC,
  input  logic [1:0]       DST,
  output logic [WIDTH-1:0] RESULT,
  output logic             MRWE,
  output logic             WA1,
  output logic             WA0,
  output logic             BUSY,
  output logic             DONE,
  output logic             FZ,
  output logic             FC,
  output logic             FN,
  output logic             ILLEGAL
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int CW = (SHIFT_W > $clog2(WIDTH)) ? SHIFT_W : $clog2(WIDTH);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [1:0]       dst_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sh_val;
  logic             sh_c;
  logic [WIDTH-1:0] res_n;
  logic             c_n;
  logic             last;
  logic             illegal_end;

`ifdef EXEC_MUL_EN
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_p;
  logic [2*WIDTH-1:0] mul_nxt;

  assign mul_nxt = mul_p + (b_q[0] ? mul_a : '0);
`endif

  assign WA1 = dst_q[1];
  assign WA0 = dst_q[0];

  assign sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};

  // a_q doubles as the shift register; carry is the bit falling off the end
  assign sh_val = (op_q == OP_SHL) ? {a_q[WIDTH-2:0], 1'b0} : {1'b0, a_q[WIDTH-1:1]};
  assign sh_c   = (op_q == OP_SHL) ? a_q[WIDTH-1] : a_q[0];

  always_comb begin
    res_n       = '0;
    c_n         = 1'b0;
    last        = 1'b1;
    illegal_end = 1'b0;
    case (op_q)
      OP_ADD: {c_n, res_n} = sum;
      OP_SUB: {c_n, res_n} = diff;
      OP_AND: res_n = a_q & b_q;
      OP_OR:  res_n = a_q | b_q;
      OP_XOR: res_n = a_q ^ b_q;
      OP_SHL, OP_SHR: begin
        last = (cnt <= CW'(1));
        if (cnt == '0) begin
          res_n = a_q;
        end else begin
          res_n = sh_val;
          c_n   = sh_c;
        end
      end
      default: begin
`ifdef EXEC_MUL_EN
        last  = (cnt == '0);
        res_n = mul_nxt[WIDTH-1:0];
        c_n   = |mul_nxt[2*WIDTH-1:WIDTH];
`else
        illegal_end = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      dst_q   <= '0;
      cnt     <= '0;
      RESULT  <= '0;
      FZ      <= 1'b0;
      FC      <= 1'b0;
      FN      <= 1'b0;
      MRWE    <= 1'b0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      ILLEGAL <= 1'b0;
`ifdef EXEC_MUL_EN
      mul_a   <= '0;
      mul_p   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            op_q  <= OP;
            a_q   <= OPA;
            b_q   <= OPB;
            cin_q <= OPC[0];
            dst_q <= DST;
            cnt   <= (OP == OP_MUL) ? CW'(WIDTH - 1) : CW'(OPB[SHIFT_W-1:0]);
            BUSY  <= 1'b1;
            state <= EXEC;
`ifdef EXEC_MUL_EN
            mul_a   <= {{WIDTH{1'b0}}, OPA};
            mul_p   <= '0;
            ILLEGAL <= 1'b0;
`else
            ILLEGAL <= (OP == OP_MUL);
`endif
          end
        end
        EXEC: begin
          if (illegal_end) begin
            ILLEGAL <= 1'b0;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end else if (last) begin
            RESULT <= res_n;
            FC     <= c_n;
            FZ     <= (res_n == '0);
            FN     <= res_n[WIDTH-1];
            MRWE   <= 1'b1;
            DONE   <= 1'b1;
            state  <= WB;
          end else begin
            cnt <= cnt - 1'b1;
`ifdef EXEC_MUL_EN
            if (op_q == OP_MUL) begin
              mul_p <= mul_nxt;
              mul_a <= mul_a << 1;
              b_q   <= b_q >> 1;
            end else
`endif
            a_q <= sh_val;
          end
        end
        WB: begin
          MRWE  <= 1'b0;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// Randomized and directed bench for exec_unit_mc against an arithmetic reference model.
module tb_exec_unit_mc;

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [2:0] OP;
  logic [7:0] OPA, OPB, OPC;
  logic [1:0] DST;
  logic [7:0] RESULT;
  logic       MRWE, WA1, WA0, BUSY, DONE, FZ, FC, FN, ILLEGAL;

  int errors = 0;
  int checks = 0;
  int hold_res = 0, hold_fc = 0, hold_fz = 0, hold_fn = 0;

  exec_unit_mc dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .OPA(OPA), .OPB(OPB),
    .OPC(OPC), .DST(DST), .RESULT(RESULT), .MRWE(MRWE), .WA1(WA1), .WA0(WA0),
    .BUSY(BUSY), .DONE(DONE), .FZ(FZ), .FC(FC), .FN(FN), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: result, carry, number of EXEC cycles and illegal flag from plain arithmetic.
  function automatic void model(input int op, input int a, input int b, input int cin,
                                output int r, output int c, output int cyc, output int ill);
    int n;
    n = b % 8;
    r = 0; c = 0; cyc = 1; ill = 0;
    case (op)
      0: begin r = a + b + cin; c = (r > 255) ? 1 : 0; r = r % 256; end
      1: begin c = (a < b + cin) ? 1 : 0; r = (a - b - cin + 512) % 256; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        r = (a << n) % 256;
        if (n > 0) begin c = (a >> (8 - n)) & 1; cyc = n; end
      end
      6: begin
        r = a >> n;
        if (n > 0) begin c = (a >> (n - 1)) & 1; cyc = n; end
      end
      default: begin
`ifdef EXEC_MUL_EN
        r = (a * b) % 256; c = ((a * b) > 255) ? 1 : 0; cyc = 8;
`else
        ill = 1;
`endif
      end
    endcase
  endfunction

  task automatic check_outputs_hold(input string tag);
    check({tag, "_result"}, RESULT, hold_res);
    check({tag, "_fc"}, FC, hold_fc);
    check({tag, "_fz"}, FZ, hold_fz);
    check({tag, "_fn"}, FN, hold_fn);
  endtask

  // Issue one op from IDLE; if hold is set, keep a competing ADD request on START while busy.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [1:0] dst, input bit hold);
    int er, ec, ecyc, ill, k;
    model(int'(op), int'(a), int'(b), int'(c[0]), er, ec, ecyc, ill);
    START = 1'b1; OP = op; OPA = a; OPB = b; OPC = c; DST = dst;
    step();
    k = 1;
    check("wa_latched", {WA1, WA0}, dst);
    check("illegal_pulse", ILLEGAL, ill);
    if (ill != 0) begin
      START = 1'b0;
      check("illegal_busy", BUSY, 1);
      check("illegal_mrwe", MRWE, 0);
      step();
      check("illegal_clear", ILLEGAL, 0);
      check("illegal_idle", BUSY, 0);
      check("illegal_nowb", MRWE, 0);
      check_outputs_hold("illegal_keep");
      return;
    end
    while (MRWE !== 1'b1 && k <= 20) begin
      check("busy_exec", BUSY, 1);
      START = hold; OP = 3'b000;
      OPA = 8'($urandom); OPB = 8'($urandom); OPC = 8'($urandom); DST = 2'($urandom);
      step();
      k++;
    end
    check("mrwe_latency", k, ecyc + 1);
    check("done", DONE, 1);
    check("busy_wb", BUSY, 1);
    check("wa_wb", {WA1, WA0}, dst);
    check("result", RESULT, er);
    check("fc", FC, ec);
    check("fz", FZ, (er == 0) ? 1 : 0);
    check("fn", FN, (er >> 7) & 1);
    hold_res = er; hold_fc = ec; hold_fz = (er == 0) ? 1 : 0; hold_fn = (er >> 7) & 1;
    START = hold;
    step();
    START = 1'b0;
    check("mrwe_pulse", MRWE, 0);
    check("done_pulse", DONE, 0);
    check("idle_after_wb", BUSY, 0);
    check_outputs_hold("hold_after_wb");
  endtask

  initial begin
    int seen;
    RESET = 1'b1; START = 1'b0; OP = '0; OPA = '0; OPB = '0; OPC = '0; DST = '0;
    step();
    step();
    check("rst_result", RESULT, 0);
    check("rst_flags", {FZ, FC, FN}, 0);
    check("rst_pulses", {MRWE, DONE, ILLEGAL}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_wa", {WA1, WA0}, 0);
    RESET = 1'b0;
    step();

    run_op(3'b000, 8'h7F, 8'h01, 8'h00, 2'b01, 1'b0);
    check("t1_result_const", RESULT, 8'h80);
    run_op(3'b001, 8'h10, 8'h20, 8'hFF, 2'b11, 1'b0);
    check("t2_result_const", RESULT, 8'hEF);
    run_op(3'b000, 8'hFF, 8'h01, 8'h00, 2'b00, 1'b0);
    check("t2_zero_carry", {FZ, FC}, 2'b11);
    run_op(3'b101, 8'h81, 8'h03, 8'h00, 2'b10, 1'b0);
    check("t3_shl_const", RESULT, 8'h08);
    run_op(3'b110, 8'h81, 8'h00, 8'hFF, 2'b01, 1'b0);
    check("t3_shr0_const", RESULT, 8'h81);

    // Competing STARTs during a long op and during WB must be dropped
    run_op(3'b101, 8'hC3, 8'h07, 8'h00, 2'b10, 1'b1);
    run_op(3'b111, 8'h10, 8'h11, 8'h00, 2'b01, 1'b1);
    run_op(3'b000, 8'h22, 8'h33, 8'hFF, 2'b11, 1'b0);

    // Reset mid-operation discards the op
    START = 1'b1; OP = 3'b101; OPA = 8'h5A; OPB = 8'h07; OPC = 8'h00; DST = 2'b11;
    step();
    START = 1'b0;
    step();
    step();
    step();
    RESET = 1'b1;
    #1;
    check("midrst_result", RESULT, 0);
    check("midrst_flags", {FZ, FC, FN}, 0);
    check("midrst_ctl", {MRWE, DONE, BUSY, ILLEGAL, WA1, WA0}, 0);
    step();
    RESET = 1'b0;
    hold_res = 0; hold_fc = 0; hold_fz = 0; hold_fn = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (MRWE === 1'b1) seen++;
    end
    check("midrst_no_wb", seen, 0);
    run_op(3'b100, 8'hF0, 8'h3C, 8'h00, 2'b10, 1'b0);

    // Unsupported/multiply op after a known result
    run_op(3'b011, 8'h81, 8'h02, 8'h00, 2'b01, 1'b0);
    run_op(3'b111, 8'hFF, 8'hFF, 8'hFF, 2'b10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 2'($urandom),
             1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
Multi-cycle execute stage directly downstream of the main register file. Consumes the OUTA/OUTB/OUTC read buses and computes an 8-bit result. Drives the result back onto the register-file write bus together with MRWE and WA1:WA0. Single-cycle logic/arithmetic ops and iterative shift/multiply ops share one FSM; the block holds BUSY until write-back completes.

Parameters:
WIDTH, 8, datapath width; the CPU uses 8 only.
SHIFT_W, 3, number of low OPB bits used as shift count.

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  operation request; sampled only in IDLE
OP  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
OPA  input  WIDTH  operand A (register file OUTA)
OPB  input  WIDTH  operand B / shift count (register file OUTB)
OPC  input  WIDTH  carry-in source (register file OUTC, 00 or FF); cin = OPC[0]
DST  input  2  destination register: 00 A, 01 B, 10 C, 11 IX
RESULT  output  WIDTH  registered result; drives register-file IN
MRWE  output  1  register-file write enable, one-cycle pulse
WA1  output  1  destination address bit 1
WA0  output  1  destination address bit 0
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle pulse, coincident with MRWE
FZ  output  1  zero flag
FC  output  1  carry/borrow flag
FN  output  1  negative flag (RESULT[WIDTH-1])
ILLEGAL  output  1  one-cycle pulse on an unsupported op

Behaviour:
- Reset (async, any state): FSM to IDLE. RESULT=0, FZ/FC/FN=0, MRWE=0, DONE=0, BUSY=0, ILLEGAL=0, WA1:WA0=00. An in-flight op is discarded and produces no write.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - On START=1, latch OP, OPA, OPB, cin and DST at the edge, then go to EXEC.
  - START=0 → remain in IDLE.
- EXEC:
  - ADD/SUB/AND/OR/XOR take exactly 1 cycle.
  - SHL/SHR take n = OPB[SHIFT_W-1:0] cycles, one bit per cycle; n=0 takes 1 cycle with result = OPA and C=0.
  - MUL is shift-add over 8 cycles; result is the low byte.
  - On the last EXEC edge, register RESULT and flags, then go to WB.
- WB: lasts exactly 1 cycle. MRWE=1, DONE=1, WA1:WA0 = latched DST, RESULT valid. Next state IDLE.
- Latency: START edge → MRWE high for 1 cycle after (EXEC cycles) cycles.
  - Single ops: MRWE in the 2nd cycle after START.
  - MUL: MRWE in the 9th cycle after START.
- WA1:WA0 hold latched DST from EXEC until the next accepted START.
- RESULT and flags hold after WB until the next op's final EXEC edge.
- START while BUSY (including during WB) is ignored and not queued. Next START is accepted in the cycle after WB.
- Flags, all set on the final EXEC edge:
  - FZ = (result == 0); FN = result MSB.
  - FC for ADD = carry out of A+B+cin.
  - FC for SUB = borrow, i.e. A < B+cin; result = A-B-cin mod 256.
  - FC for logic ops = 0.
  - FC for SHL/SHR = last bit shifted out.
  - FC for MUL = 1 if the product high byte != 0.
- Operand buses may change after the START edge without effect.

Optional Feature:
Macro EXEC_MUL_EN.
- Defined: OP=111 performs MUL as above.
- Undefined: no multiplier logic. OP=111 goes EXEC (1 cycle) → IDLE with ILLEGAL pulsed during that EXEC cycle. No WB cycle, MRWE never asserted, RESULT and flags unchanged.

Test Plan:
1. Reset, then START OP=ADD OPA=7F OPB=01 OPC=00 DST=01 → MRWE/DONE high exactly 1 cycle, 2 cycles after START; RESULT=80, WA1:WA0=01, FN=1, FZ=0, FC=0; BUSY high 2 cycles.
2. SUB OPA=10 OPB=20 OPC=FF DST=11 → RESULT=EF, FC=1, FN=1, WA=11; then ADD FF+01 cin=0 → RESULT=00, FZ=1, FC=1.
3. SHL OPA=81 OPB=03 → 3 EXEC cycles, RESULT=08, FC=0; SHR OPA=81 OPB=00 → 1 EXEC cycle, RESULT=81, FC=0.
4. MUL OPA=10 OPB=11 (EXEC_MUL_EN defined) → MRWE 9 cycles after START, RESULT=10, FC=1. Assert START with OP=ADD in cycles 3 and 9 (WB) → both ignored; ADD issued in the cycle after WB is accepted.
5. MUL started, RESET pulsed in EXEC cycle 4 → all outputs 0 immediately, no MRWE afterwards, next START executes normally.
6. Build without EXEC_MUL_EN, OP=111 → ILLEGAL one pulse, MRWE never high, RESULT/flags retain prior values, BUSY high 1 cycle.
